// File: rtl/cs_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cs_loader
//  Purpose  : Power-on control store loader. After reset (or a reload request
//             once loaded) copies DEPTH = 2**ADDR_WIDTH microcode words from
//             the EPROM into the control store RAM, then raises cs_ready.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk       in   1           system clock, rising edge
//    _reset    in   1           asynchronous active-low reset
//    reload    in   1           request a fresh copy (honoured only when loaded)
//    rom_data  in   DATA_WIDTH  EPROM read data
//    rom_addr  out  ADDR_WIDTH  EPROM address
//    rom_oe    out  1           EPROM output enable, active high
//    ram_addr  out  ADDR_WIDTH  control store RAM address
//    ram_data  out  DATA_WIDTH  control store RAM write data
//    ram__w    out  1           control store RAM write strobe, active low
//    busy      out  1           copy in progress
//    cs_ready  out  1           control store loaded and valid (registered)
// ============================================================================
module cs_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 64,
  parameter int ROM_LATENCY = 1   // legal range 1..15
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  reload,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram__w,
  output logic                  busy,
  output logic                  cs_ready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WRITE   = 3'd2,
    S_RECOVER = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;                 // DEPTH-1
  localparam logic [3:0]            WAIT_LAST = 4'(ROM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [3:0]            wait_q, wait_d;
  logic                  rom_oe_q, ram_w_n_q, busy_q, cs_ready_q;

  // Next-state and datapath decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wait_d     = wait_q;
    ram_addr_d = ram_addr_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        addr_d  = '0;
        wait_d  = '0;
      end
      S_FETCH: begin
        wait_d = wait_q + 4'd1;
        if (wait_q == WAIT_LAST) begin
          // ram_addr and ram_data change on the same edge that drops the
          // strobe and then stay put through RECOVER for RAM hold time.
          data_d     = rom_data;
          ram_addr_d = addr_q;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          wait_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        if (reload) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Control outputs are flops loaded from the next state so
  // they switch exactly with the state and never glitch (cs_ready drives the
  // control-store clock mux and the master reset).
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wait_q     <= '0;
      ram_addr_q <= '0;
      rom_oe_q   <= 1'b0;
      ram_w_n_q  <= 1'b1;
      busy_q     <= 1'b0;
      cs_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wait_q     <= wait_d;
      ram_addr_q <= ram_addr_d;
      rom_oe_q   <= (state_d == S_FETCH);
      ram_w_n_q  <= (state_d != S_WRITE);
      busy_q     <= (state_d inside {S_FETCH, S_WRITE, S_RECOVER});
      cs_ready_q <= (state_d == S_DONE);
    end
  end

  assign rom_addr = addr_q;
  assign rom_oe   = rom_oe_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = data_q;
  assign ram__w   = ram_w_n_q;
  assign busy     = busy_q;
  assign cs_ready = cs_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_cs_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cs_loader
//  Purpose  : Self-checking bench for cs_loader. Two instances run side by
//             side (ROM_LATENCY 1 and 3), each with its own EPROM model and
//             write monitor. Expected write sequence and completion times are
//             derived from the copy rules: word i lands at address i, and
//             cs_ready rises 1 + DEPTH*(ROM_LATENCY+2) edges after start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cs_loader;

  localparam int AW    = 8;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << AW;

  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic reload = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int L = (g == 0) ? 1 : 3;
    localparam int S = (L > 1) ? L - 2 : 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rom_data;
    logic [AW-1:0] rom_addr;
    logic          rom_oe;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wn;
    logic          busy;
    logic          cs_ready;

    cs_loader #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ROM_LATENCY(L)
    ) u_dut (
      .clk     (clk),
      ._reset  (rst_n),
      .reload  (reload),
      .rom_data(rom_data),
      .rom_addr(rom_addr),
      .rom_oe  (rom_oe),
      .ram_addr(ram_addr),
      .ram_data(ram_data),
      .ram__w  (ram_wn),
      .busy    (busy),
      .cs_ready(cs_ready)
    );

    // EPROM model: the word for an address appears L-1 edges after the
    // address is presented; anything else reads back as inverted garbage.
    logic [AW-1:0] pipe_a  [4];
    logic          pipe_oe [4];
    always @(posedge clk) begin
      pipe_a[0]  <= rom_addr;
      pipe_oe[0] <= rom_oe;
      for (int k = 1; k < 4; k++) begin
        pipe_a[k]  <= pipe_a[k-1];
        pipe_oe[k] <= pipe_oe[k-1];
      end
    end
    assign rom_data = (L == 1) ? (rom_oe ? mem[rom_addr] : ~mem[rom_addr])
                               : (pipe_oe[S] ? mem[pipe_a[S]] : ~mem[pipe_a[S]]);

    // Write monitor: pulse n must carry address n and word mem[n].
    int            pulses = 0;
    logic          prev_wn = 1'b1;
    logic          after_pulse = 1'b0;
    logic [AW-1:0] hold_a;
    logic [DW-1:0] hold_d;
    always @(negedge clk) begin
      if (rst_n !== 1'b1 || (busy === 1'b0 && cs_ready === 1'b0)) begin
        pulses      = 0;
        prev_wn     = 1'b1;
        after_pulse = 1'b0;
      end else begin
        if (after_pulse) begin
          chk($sformatf("L%0d_hold_addr", L), 64'(ram_addr), 64'(hold_a));
          chk($sformatf("L%0d_hold_data", L), ram_data, hold_d);
          after_pulse = 1'b0;
        end
        if (rom_oe === 1'b1)
          chk($sformatf("L%0d_rom_addr", L), 64'(rom_addr), 64'(pulses));
        if (ram_wn !== 1'b1) begin
          chk($sformatf("L%0d_w_single", L), 64'(prev_wn), 64'(1));
          chk($sformatf("L%0d_w_addr", L), 64'(ram_addr), 64'(pulses));
          chk($sformatf("L%0d_w_data", L), ram_data, mem[pulses % DEPTH]);
          chk($sformatf("L%0d_w_oe", L), 64'(rom_oe), 64'(0));
          hold_a      = ram_addr;
          hold_d      = ram_data;
          after_pulse = 1'b1;
          pulses++;
        end
        prev_wn = ram_wn;
      end
    end
  end

  task automatic fill_mem(input bit random);
    for (int i = 0; i < DEPTH; i++) begin
      g_lane[0].mem[i] = random ? {$urandom, $urandom} : {8{8'(i)}};
      g_lane[1].mem[i] = random ? {$urandom, $urandom} : {8{8'(i)}};
    end
  endtask

  // {rom_addr, ram_addr, rom_oe, ram__w, busy, cs_ready} in reset is 0,0,0,1,0,0.
  task automatic chk_reset(input string tag);
    chk({tag, "_ctl0"}, 64'({g_lane[0].rom_addr, g_lane[0].ram_addr, g_lane[0].rom_oe,
                             g_lane[0].ram_wn, g_lane[0].busy, g_lane[0].cs_ready}), 64'h4);
    chk({tag, "_dat0"}, g_lane[0].ram_data, 64'h0);
    chk({tag, "_ctl1"}, 64'({g_lane[1].rom_addr, g_lane[1].ram_addr, g_lane[1].rom_oe,
                             g_lane[1].ram_wn, g_lane[1].busy, g_lane[1].cs_ready}), 64'h4);
    chk({tag, "_dat1"}, g_lane[1].ram_data, 64'h0);
  endtask

  // Runs from the edge that leaves IDLE; optionally pulses reload mid-copy.
  task automatic run_copy(input int reload_at);
    int rdy0 = 0;
    int rdy1 = 0;
    bit drop0 = 1'b0;
    bit drop1 = 1'b0;
    for (int cyc = 1; cyc <= 1300; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      reload = (cyc == reload_at);
      if (cyc == 1) begin
        chk("busy_start0", 64'(g_lane[0].busy), 64'(1));
        chk("busy_start1", 64'(g_lane[1].busy), 64'(1));
      end
      if (rdy0 == 0 && g_lane[0].cs_ready === 1'b1) rdy0 = cyc;
      if (rdy1 == 0 && g_lane[1].cs_ready === 1'b1) rdy1 = cyc;
      if (rdy0 != 0 && g_lane[0].cs_ready !== 1'b1) drop0 = 1'b1;
      if (rdy1 != 0 && g_lane[1].cs_ready !== 1'b1) drop1 = 1'b1;
    end
    reload = 1'b0;
    chk("ready_cycle_L1", 64'(rdy0), 64'(1 + DEPTH * (1 + 2)));
    chk("ready_cycle_L3", 64'(rdy1), 64'(1 + DEPTH * (3 + 2)));
    chk("ready_drop_L1", 64'(drop0), 64'(0));
    chk("ready_drop_L3", 64'(drop1), 64'(0));
    chk("pulses_L1", 64'(g_lane[0].pulses), 64'(DEPTH));
    chk("pulses_L3", 64'(g_lane[1].pulses), 64'(DEPTH));
    chk("busy_done0", 64'(g_lane[0].busy), 64'(0));
    chk("busy_done1", 64'(g_lane[1].busy), 64'(0));
  endtask

  task automatic pulse_reload_in_done();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reload = 1'b0;
    chk("reload_ready0", 64'(g_lane[0].cs_ready), 64'(0));
    chk("reload_ready1", 64'(g_lane[1].cs_ready), 64'(0));
    chk("reload_busy0", 64'(g_lane[0].busy), 64'(0));
    chk("reload_busy1", 64'(g_lane[1].busy), 64'(0));
  endtask

  initial begin
    bit reached = 1'b0;

    // Power-on: counting-pattern image, reset seen asynchronously.
    fill_mem(1'b0);
    #2 rst_n = 1'b0;
    #1 chk_reset("por_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("por_held");
    rst_n = 1'b1;

    // First copy, with a reload pulse that must be ignored mid-copy.
    run_copy($urandom_range(10, 700));

    // Reload from DONE with a random image.
    fill_mem(1'b1);
    pulse_reload_in_done();
    run_copy(0);

    // Reset in the middle of a copy at word 100, then a clean full copy.
    fill_mem(1'b1);
    pulse_reload_in_done();
    for (int cyc = 0; cyc < 1000 && !reached; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      if (g_lane[0].pulses >= 100) reached = 1'b1;
    end
    chk("reach_word100", 64'(reached), 64'(1));
    rst_n = 1'b0;
    #1 chk_reset("mid_async");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("mid_held");
    fill_mem(1'b1);
    rst_n = 1'b1;
    run_copy($urandom_range(10, 700));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
